// File: rtl/bp_me_mem_concentrator_pkg.sv
// Shared helpers for the memory-channel concentrator.
//   safe_clog2 : index width for a structure of n entries, never less than 1 bit.
package bp_me_mem_concentrator_pkg;

   // Width needed to index n entries, clamped to 1 so single-entry cases still
   // get a legal one-bit vector.
   function automatic int safe_clog2(input int n);
      int r;
      r = 32'sd1;
      while ((32'sd1 << r) < n) begin
         r = r + 32'sd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bp_me_mem_concentrator_if.sv
// Bundle of the CCE-side and memory-side handshake signals of one concentrator.
//   slave  : view used by the concentrator itself
//   master : view used by the surrounding environment (CCEs + memory)
interface bp_me_mem_concentrator_if #(
   parameter int num_cce_p    = 2,
   parameter int cmd_width_p  = 64,
   parameter int resp_width_p = 64
);
   logic [num_cce_p-1:0][cmd_width_p-1:0]  cce_cmd_i;
   logic [num_cce_p-1:0]                   cce_cmd_v_i;
   logic [num_cce_p-1:0]                   cce_cmd_yumi_o;
   logic [cmd_width_p-1:0]                 mem_cmd_o;
   logic                                   mem_cmd_v_o;
   logic                                   mem_cmd_yumi_i;
   logic [resp_width_p-1:0]                mem_resp_i;
   logic                                   mem_resp_v_i;
   logic                                   mem_resp_ready_o;
   logic [num_cce_p-1:0][resp_width_p-1:0] cce_resp_o;
   logic [num_cce_p-1:0]                   cce_resp_v_o;
   logic [num_cce_p-1:0]                   cce_resp_ready_i;

   modport slave (
      input  cce_cmd_i, cce_cmd_v_i, mem_cmd_yumi_i, mem_resp_i, mem_resp_v_i, cce_resp_ready_i,
      output cce_cmd_yumi_o, mem_cmd_o, mem_cmd_v_o, mem_resp_ready_o, cce_resp_o, cce_resp_v_o
   );

   modport master (
      output cce_cmd_i, cce_cmd_v_i, mem_cmd_yumi_i, mem_resp_i, mem_resp_v_i, cce_resp_ready_i,
      input  cce_cmd_yumi_o, mem_cmd_o, mem_cmd_v_o, mem_resp_ready_o, cce_resp_o, cce_resp_v_o
   );
endinterface

// File: rtl/bp_me_mem_concentrator_checker.sv
// Simulation-only protocol checks for the concentrator.
//   clk_i, reset_i      : clock and synchronous reset
//   mem_resp_v_i        : memory response valid
//   tracker_empty_i     : no command is in flight
//   cce_cmd_yumi_i      : per-CCE command consume strobes
module bp_me_mem_concentrator_checker #(
   parameter int num_cce_p = 2
) (
   input logic                 clk_i,
   input logic                 reset_i,
   input logic                 mem_resp_v_i,
   input logic                 tracker_empty_i,
   input logic [num_cce_p-1:0] cce_cmd_yumi_i
);

   // A response with nothing in flight means memory and the tracker disagree.
   unexpected_response_a: assert property (@(posedge clk_i) disable iff (reset_i)
      !(mem_resp_v_i && tracker_empty_i))
      else $error("unexpected response");

   // Only one CCE may be consumed per cycle.
   yumi_onehot_a: assert property (@(posedge clk_i) disable iff (reset_i)
      $onehot0(cce_cmd_yumi_i))
      else $error("multiple command yumis");

endmodule

// File: rtl/bp_me_mem_concentrator_tracker.sv
// In-flight tracker: FIFO of issuing-CCE ids plus an occupancy count.
//   push_i/id_i : record the CCE of a command loaded toward memory
//   pop_i       : a response was accepted; retire the head id
//   head_o      : id of the oldest in-flight command
//   full_o      : max_outstanding_p commands in flight
//   empty_o     : nothing in flight
module bp_me_mem_concentrator_tracker
   import bp_me_mem_concentrator_pkg::*;
#(
   parameter int depth_p    = 4,
   parameter int id_width_p = 1
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  push_i,
   input  logic [id_width_p-1:0] id_i,
   input  logic                  pop_i,
   output logic [id_width_p-1:0] head_o,
   output logic                  full_o,
   output logic                  empty_o
);
   localparam int ptr_width_lp = safe_clog2(depth_p);
   localparam int cnt_width_lp = safe_clog2(depth_p + 1);

   typedef logic [ptr_width_lp-1:0] ptr_t;
   typedef logic [cnt_width_lp-1:0] cnt_t;

   localparam ptr_t last_ptr_lp = ptr_t'(depth_p - 1);
   localparam cnt_t depth_cnt_lp = cnt_t'(depth_p);

   logic [id_width_p-1:0] ids_r [depth_p];
   ptr_t                  wr_ptr_r;
   ptr_t                  rd_ptr_r;
   cnt_t                  count_r;
   logic                  push_en_s;
   logic                  pop_en_s;

   // Pointers wrap at the depth, which need not be a power of two.
   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == last_ptr_lp) ? ptr_t'(0) : ptr_t'(p + ptr_t'(1));
   endfunction

   assign full_o    = (count_r == depth_cnt_lp);
   assign empty_o   = (count_r == cnt_t'(0));
   assign push_en_s = push_i & ~full_o;
   assign pop_en_s  = pop_i & ~empty_o;
   assign head_o    = ids_r[rd_ptr_r];

   // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_r <= ptr_t'(0);
         rd_ptr_r <= ptr_t'(0);
         count_r  <= cnt_t'(0);
      end else begin
         if (push_en_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
         if (pop_en_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
         case ({push_en_s, pop_en_s})
            2'b10:   count_r <= cnt_t'(count_r + cnt_t'(1));
            2'b01:   count_r <= cnt_t'(count_r - cnt_t'(1));
            default: count_r <= count_r;
         endcase
      end
   end

   // Id storage; cleared on reset so the head never presents stale data.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < depth_p; i++) begin
            ids_r[i] <= {id_width_p{1'b0}};
         end
      end else if (push_en_s) begin
         ids_r[wr_ptr_r] <= id_i;
      end
   end

endmodule

// File: rtl/bp_me_mem_concentrator.sv
// N-to-1 memory-channel concentrator.
//   clk_i    : clock
//   reset_i  : synchronous active-high reset, discards all in-flight state
//   bus      : slave view of the CCE/memory handshakes
//     cce_cmd_*  -> round-robin arbitrated into a one-entry command register
//     mem_cmd_*  <- registered command toward memory
//     mem_resp_* -> in-order responses, tagged with the tracked issuing CCE
//     cce_resp_* <- one-entry response register, payload broadcast, one-hot valid
module bp_me_mem_concentrator
   import bp_me_mem_concentrator_pkg::*;
#(
   parameter int num_cce_p         = 2,
   parameter int cmd_width_p       = 64,
   parameter int resp_width_p      = 64,
   parameter int max_outstanding_p = 4
) (
   input logic                      clk_i,
   input logic                      reset_i,
   bp_me_mem_concentrator_if.slave  bus
);
   localparam int id_width_lp = safe_clog2(num_cce_p);
   typedef logic [id_width_lp-1:0] id_t;
   localparam id_t last_id_lp = id_t'(num_cce_p - 1);

   logic [cmd_width_p-1:0]  cmd_r;
   logic                    cmd_full_r;
   logic [resp_width_p-1:0] resp_r;
   id_t                     resp_dest_r;
   logic                    resp_full_r;
   id_t                     rr_ptr_r;

   id_t                     grant_id_s;
   logic                    grant_found_s;
   logic                    load_en_s;
   logic [num_cce_p-1:0]    yumi_s;
   id_t                     rr_next_s;
   logic                    tracker_full_s;
   logic                    tracker_empty_s;
   id_t                     tracker_head_s;
   logic                    resp_ready_s;
   logic                    resp_accept_s;
   logic                    dest_ready_s;
   logic [num_cce_p-1:0]    resp_v_s;

   // Round-robin search: first valid CCE at or after rr_ptr_r, wrapping.
   always_comb begin : arb_search
      int cand;
      grant_found_s = 1'b0;
      grant_id_s    = id_t'(0);
      cand          = 32'sd0;
      for (int off = 0; off < num_cce_p; off++) begin
         cand = int'(rr_ptr_r) + off;
         if (cand >= num_cce_p) begin
            cand = cand - num_cce_p;
         end else begin
            cand = cand;
         end
         if (!grant_found_s && bus.cce_cmd_v_i[cand]) begin
            grant_found_s = 1'b1;
            grant_id_s    = id_t'(cand);
         end else begin
            grant_id_s    = grant_id_s;
         end
      end
   end

   // A full tracker blocks loading even if a response retires this cycle.
   assign load_en_s = (~cmd_full_r | bus.mem_cmd_yumi_i) & ~tracker_full_s & grant_found_s;
   assign rr_next_s = (grant_id_s == last_id_lp) ? id_t'(0) : id_t'(grant_id_s + id_t'(1));

   // One-hot yumi toward the granted CCE, only in a loading cycle.
   always_comb begin
      yumi_s = {num_cce_p{1'b0}};
      if (load_en_s) begin
         yumi_s[grant_id_s] = 1'b1;
      end else begin
         yumi_s = {num_cce_p{1'b0}};
      end
   end

   // Command register and round-robin pointer.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cmd_r      <= {cmd_width_p{1'b0}};
         cmd_full_r <= 1'b0;
         rr_ptr_r   <= id_t'(0);
      end else if (load_en_s) begin
         cmd_r      <= bus.cce_cmd_i[grant_id_s];
         cmd_full_r <= 1'b1;
         rr_ptr_r   <= rr_next_s;
      end else if (bus.mem_cmd_yumi_i) begin
         cmd_full_r <= 1'b0;
      end
   end

   bp_me_mem_concentrator_tracker #(
      .depth_p    (max_outstanding_p),
      .id_width_p (id_width_lp)
   ) tracker (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .push_i  (load_en_s),
      .id_i    (grant_id_s),
      .pop_i   (resp_accept_s),
      .head_o  (tracker_head_s),
      .full_o  (tracker_full_s),
      .empty_o (tracker_empty_s)
   );

   // The response slot frees up in the same cycle its destination drains it.
   assign dest_ready_s  = bus.cce_resp_ready_i[resp_dest_r];
   assign resp_ready_s  = ~tracker_empty_s & (~resp_full_r | dest_ready_s);
   assign resp_accept_s = bus.mem_resp_v_i & resp_ready_s;

   // Response register, tagged with the CCE at the tracker head.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         resp_r      <= {resp_width_p{1'b0}};
         resp_dest_r <= id_t'(0);
         resp_full_r <= 1'b0;
      end else if (resp_accept_s) begin
         resp_r      <= bus.mem_resp_i;
         resp_dest_r <= tracker_head_s;
         resp_full_r <= 1'b1;
      end else if (resp_full_r && dest_ready_s) begin
         resp_full_r <= 1'b0;
      end
   end

   // Decode the held destination into the one-hot response valid.
   always_comb begin
      resp_v_s = {num_cce_p{1'b0}};
      for (int i = 0; i < num_cce_p; i++) begin
         resp_v_s[i] = resp_full_r & (resp_dest_r == id_t'(i));
      end
   end

   assign bus.cce_cmd_yumi_o   = yumi_s;
   assign bus.mem_cmd_o        = cmd_r;
   assign bus.mem_cmd_v_o      = cmd_full_r;
   assign bus.mem_resp_ready_o = resp_ready_s;
   assign bus.cce_resp_o       = {num_cce_p{resp_r}};
   assign bus.cce_resp_v_o     = resp_v_s;

   bp_me_mem_concentrator_checker #(
      .num_cce_p (num_cce_p)
   ) checker_inst (
      .clk_i           (clk_i),
      .reset_i         (reset_i),
      .mem_resp_v_i    (bus.mem_resp_v_i),
      .tracker_empty_i (tracker_empty_s),
      .cce_cmd_yumi_i  (yumi_s)
   );

endmodule
